// File: rtl/mips_run_ctrl.sv
// Run/debug sequencer for mips_single: reset, gated run, register-file dump stream.
// Optional breakpoint stop is compiled in with `define RUN_CTRL_BKPT_EN.
module mips_run_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int RST_CYCLES = 2,
   parameter int CNT_W      = 32,
   parameter int MAX_CYCLES = 701,
   parameter int DUMP_FIRST = 0,
   parameter int DUMP_LAST  = 31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              abort,
   input  logic              bkpt_en,
   input  logic [ADDR_W-1:0] bkpt_addr,
   output logic              cpu_reset,
   output logic              cpu_clk_en,
   output logic [ADDR_W-1:0] cpu_start_addr,
   output logic [4:0]        cpu_peek_addr,
   input  logic              cpu_done,
   input  logic [31:0]       cpu_show,
   input  logic [ADDR_W-1:0] cpu_pc,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [4:0]        dump_idx,
   output logic [31:0]       dump_data,
   output logic              busy,
   output logic              finished,
   output logic [2:0]        status,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_DUMP, S_END} state_t;

   localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RCW-1:0]   RST_LAST  = RCW'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(MAX_CYCLES);
   localparam logic [4:0]       IDX_FIRST = 5'(DUMP_FIRST);
   localparam logic [4:0]       IDX_LAST  = 5'(DUMP_LAST);

   localparam logic [2:0] ST_NONE = 3'd0, ST_DONE = 3'd1, ST_TIMEOUT = 3'd2,
                          ST_BKPT = 3'd3, ST_ABORT = 3'd4;

   state_t              state_q, state_d;
   logic [RCW-1:0]      rst_cnt_q, rst_cnt_d;
   logic                cpu_reset_q, cpu_reset_d;
   logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
   logic [CNT_W-1:0]    cycle_q, cycle_d;
   logic [2:0]          status_q, status_d;
   logic [4:0]          load_idx_q, load_idx_d;
   logic                last_loaded_q, last_loaded_d;
   logic                dv_q, dv_d;
   logic [4:0]          di_q, di_d;
   logic [31:0]         dd_q, dd_d;

   logic bkpt_hit, limit, stop;

`ifdef RUN_CTRL_BKPT_EN
   assign bkpt_hit = bkpt_en && (cpu_pc == bkpt_addr);
`else
   logic unused_bkpt;
   assign unused_bkpt = ^{bkpt_en, bkpt_addr, cpu_pc};
   assign bkpt_hit    = 1'b0;
`endif

   // The CPU edge is withheld in the very cycle a stop condition is seen.
   assign limit      = (MAX_CYCLES != 0) && (cycle_q == LIMIT);
   assign stop       = abort || cpu_done || bkpt_hit || limit;
   assign cpu_clk_en = (state_q == S_RUN) && !stop;

   always_comb begin
      state_d       = state_q;
      rst_cnt_d     = rst_cnt_q;
      cpu_reset_d   = cpu_reset_q;
      start_addr_d  = start_addr_q;
      cycle_d       = cycle_q;
      status_d      = status_q;
      load_idx_d    = load_idx_q;
      last_loaded_d = last_loaded_q;
      dv_d          = dv_q;
      di_d          = di_q;
      dd_d          = dd_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               start_addr_d = start_addr;
               cycle_d      = '0;
               status_d     = ST_NONE;
               cpu_reset_d  = 1'b1;
               rst_cnt_d    = '0;
               state_d      = S_RESET;
            end
         end
         S_RESET: begin
            if (rst_cnt_q == RST_LAST) begin
               cpu_reset_d = 1'b0;
               state_d     = S_RUN;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            if (stop) begin
               if (abort) begin
                  status_d = ST_ABORT;
                  state_d  = S_END;
               end else begin
                  status_d      = cpu_done ? ST_DONE : (bkpt_hit ? ST_BKPT : ST_TIMEOUT);
                  load_idx_d    = IDX_FIRST;
                  last_loaded_d = 1'b0;
                  dv_d          = 1'b0;
                  state_d       = S_DUMP;
               end
            end else if (cycle_q != CNT_MAX) begin
               cycle_d = cycle_q + 1'b1;
            end
         end
         S_DUMP: begin
            // Output slot is refilled whenever it is empty or being accepted.
            if (abort) begin
               dv_d     = 1'b0;
               status_d = ST_ABORT;
               state_d  = S_END;
            end else if (!dv_q || dump_ready) begin
               if (!last_loaded_q) begin
                  dv_d = 1'b1;
                  di_d = load_idx_q;
                  dd_d = cpu_show;
                  if (load_idx_q == IDX_LAST) last_loaded_d = 1'b1;
                  else                        load_idx_d    = load_idx_q + 5'd1;
               end else begin
                  dv_d    = 1'b0;
                  state_d = S_END;
               end
            end
         end
         S_END:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         rst_cnt_q     <= '0;
         cpu_reset_q   <= 1'b1;
         start_addr_q  <= '0;
         cycle_q       <= '0;
         status_q      <= ST_NONE;
         load_idx_q    <= '0;
         last_loaded_q <= 1'b0;
         dv_q          <= 1'b0;
         di_q          <= '0;
         dd_q          <= '0;
      end else begin
         state_q       <= state_d;
         rst_cnt_q     <= rst_cnt_d;
         cpu_reset_q   <= cpu_reset_d;
         start_addr_q  <= start_addr_d;
         cycle_q       <= cycle_d;
         status_q      <= status_d;
         load_idx_q    <= load_idx_d;
         last_loaded_q <= last_loaded_d;
         dv_q          <= dv_d;
         di_q          <= di_d;
         dd_q          <= dd_d;
      end
   end

   assign cpu_reset      = cpu_reset_q;
   assign cpu_start_addr = start_addr_q;
   assign cpu_peek_addr  = load_idx_q;
   assign dump_valid     = dv_q;
   assign dump_idx       = di_q;
   assign dump_data      = dd_q;
   assign busy           = (state_q != S_IDLE);
   assign finished       = (state_q == S_END);
   assign status         = status_q;
   assign cycle_count    = cycle_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: a small CPU model (PC, halt after N edges, register file)
// plus a run-outcome reference computed from the stop rules.
module tb_mips_run_ctrl;

   localparam int          RST_CYC = 2;
   localparam int unsigned MAX_CYC = 701;
   localparam int          DUMP_N  = 32;
`ifdef RUN_CTRL_BKPT_EN
   localparam bit BKPT_BUILD = 1'b1;
`else
   localparam bit BKPT_BUILD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] start_addr;
   logic        abort;
   logic        bkpt_en;
   logic [31:0] bkpt_addr;
   logic        cpu_reset, cpu_clk_en;
   logic [31:0] cpu_start_addr;
   logic [4:0]  cpu_peek_addr;
   logic        cpu_done;
   logic [31:0] cpu_show, cpu_pc;
   logic        dump_valid, dump_ready;
   logic [4:0]  dump_idx;
   logic [31:0] dump_data;
   logic        busy, finished;
   logic [2:0]  status;
   logic [31:0] cycle_count;
   logic [2:0]  dbg_state_unused;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mips_run_ctrl dut (
      .clk(clk), .reset(reset_n), .start(start), .start_addr(start_addr),
      .abort(abort), .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr),
      .cpu_reset(cpu_reset), .cpu_clk_en(cpu_clk_en), .cpu_start_addr(cpu_start_addr),
      .cpu_peek_addr(cpu_peek_addr), .cpu_done(cpu_done), .cpu_show(cpu_show),
      .cpu_pc(cpu_pc), .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_idx(dump_idx), .dump_data(dump_data), .busy(busy), .finished(finished),
      .status(status), .cycle_count(cycle_count), .dbg_state(dbg_state_unused)
   );

   // CPU model: one instruction per enabled edge, PC advances by 4, halts after done_at edges.
   int unsigned done_at = 0;
   int unsigned executed;
   logic [31:0] regfile [DUMP_N];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)        executed <= 0;
      else if (cpu_reset)  executed <= 0;
      else if (cpu_clk_en) executed <= executed + 1;
   end

   assign cpu_done = (done_at != 0) && (executed >= done_at);
   assign cpu_pc   = cpu_start_addr + (executed << 2);
   assign cpu_show = regfile[cpu_peek_addr];

   // Observations gathered by do_run
   int          obs_rst_hi, obs_fin, obs_hold_err, obs_tail_busy;
   int unsigned obs_cc;
   logic [2:0]  obs_st;
   logic        obs_dv_after_abort;
   logic [2:0]  obs_st_after_abort;
   bit          obs_timeout;
   logic [4:0]  obs_idx_q[$];
   logic [31:0] obs_data_q[$];

   function automatic void ref_run(input int unsigned d_at, input int unsigned b_at,
                                   input bit b_en, output int unsigned cnt, output logic [2:0] st);
      int unsigned d, b, t;
      d = (d_at == 0) ? 32'hFFFF_FFFF : d_at;
      b = (b_en && BKPT_BUILD) ? b_at : 32'hFFFF_FFFF;
      t = (MAX_CYC == 0) ? 32'hFFFF_FFFF : MAX_CYC;
      cnt = d;
      if (b < cnt) cnt = b;
      if (t < cnt) cnt = t;
      if (cnt == d)      st = 3'd1;
      else if (cnt == b) st = 3'd3;
      else               st = 3'd2;
   endfunction

   task automatic fill_regfile();
      for (int i = 0; i < DUMP_N; i++) regfile[i] = $urandom;
   endtask

   // Start one run and watch it until a few idle cycles after the finished pulse.
   // ready_mode: 0 always, 1 alternating, 2 random. -1 disables abort/start/run-abort hooks.
   task automatic do_run(input logic [31:0] addr, input int ready_mode, input int abort_idx,
                         input int busy_start_idx, input int abort_run_cyc);
      bit seen_fin, prev_stall, abort_pending, abort_done, start_done;
      int tail_left;
      logic r;
      logic [4:0]  prev_idx;
      logic [31:0] prev_data;
      obs_rst_hi = 0; obs_fin = 0; obs_hold_err = 0; obs_tail_busy = 0;
      obs_cc = 0; obs_st = 0; obs_dv_after_abort = 1'b1; obs_st_after_abort = 0;
      obs_idx_q.delete(); obs_data_q.delete();
      seen_fin = 0; prev_stall = 0; abort_pending = 0; abort_done = 0; start_done = 0;
      tail_left = 4; prev_idx = 0; prev_data = 0;
      @(negedge clk);
      start = 1'b1; start_addr = addr;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         if (cpu_reset) obs_rst_hi++;
         if (prev_stall && !(dump_valid && dump_idx == prev_idx && dump_data == prev_data))
            obs_hold_err++;
         if (abort_pending) begin
            obs_dv_after_abort = dump_valid;
            obs_st_after_abort = status;
            abort_pending = 0;
         end
         abort = 1'b0; start = 1'b0;
         if (finished) begin
            obs_fin++; obs_cc = cycle_count; obs_st = status; seen_fin = 1;
         end else if (seen_fin) begin
            if (busy || cpu_reset) obs_tail_busy++;
            tail_left--;
            if (tail_left == 0) break;
         end
         case (ready_mode)
            0:       r = 1'b1;
            1:       r = cyc[0];
            default: r = 1'($urandom_range(0, 1));
         endcase
         if (abort_run_cyc >= 0 && cyc == abort_run_cyc) abort = 1'b1;
         if (dump_valid && abort_idx >= 0 && dump_idx == 5'(abort_idx) && !abort_done) begin
            abort = 1'b1; r = 1'b0; abort_pending = 1; abort_done = 1;
         end
         if (dump_valid && busy_start_idx >= 0 && dump_idx == 5'(busy_start_idx) && !start_done) begin
            start = 1'b1; start_addr = $urandom; start_done = 1;
         end
         dump_ready = r;
         if (dump_valid && r && !abort) begin
            obs_idx_q.push_back(dump_idx);
            obs_data_q.push_back(dump_data);
         end
         prev_stall = dump_valid && !r && !abort;
         prev_idx   = dump_idx;
         prev_data  = dump_data;
         @(negedge clk);
      end
      obs_timeout = !(seen_fin && tail_left == 0);
      abort = 1'b0; start = 1'b0; dump_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (cpu_reset !== 1'b1)      begin errors++; $display("FAIL reset cpu_reset: got %b want 1", cpu_reset); end
      checks++; if (cpu_clk_en !== 1'b0)     begin errors++; $display("FAIL reset cpu_clk_en: got %b want 0", cpu_clk_en); end
      checks++; if (cpu_start_addr !== '0)   begin errors++; $display("FAIL reset cpu_start_addr: got %h want 0", cpu_start_addr); end
      checks++; if (cpu_peek_addr !== '0)    begin errors++; $display("FAIL reset cpu_peek_addr: got %0d want 0", cpu_peek_addr); end
      checks++; if (dump_valid !== 1'b0)     begin errors++; $display("FAIL reset dump_valid: got %b want 0", dump_valid); end
      checks++; if (dump_idx !== '0 || dump_data !== '0) begin errors++; $display("FAIL reset dump beat: got idx=%0d data=%h want 0/0", dump_idx, dump_data); end
      checks++; if (busy !== 1'b0 || finished !== 1'b0) begin errors++; $display("FAIL reset busy/finished: got %b/%b want 0/0", busy, finished); end
      checks++; if (status !== 3'd0)         begin errors++; $display("FAIL reset status: got %0d want 0", status); end
      checks++; if (cycle_count !== '0)      begin errors++; $display("FAIL reset cycle_count: got %0d want 0", cycle_count); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      done_at = 0; bkpt_en = 1'b0;
      @(negedge clk);
      start = 1'b1; start_addr = 32'h100;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      checks++; if (busy !== 1'b1 || cpu_clk_en !== 1'b1) begin errors++; $display("FAIL midrun running: got busy=%b clk_en=%b want 1/1", busy, cpu_clk_en); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (cpu_reset !== 1'b1)  begin errors++; $display("FAIL midrun cpu_reset: got %b want 1", cpu_reset); end
      checks++; if (cpu_clk_en !== 1'b0) begin errors++; $display("FAIL midrun cpu_clk_en: got %b want 0", cpu_clk_en); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL midrun busy: got %b want 0", busy); end
      checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL midrun dump_valid: got %b want 0", dump_valid); end
      checks++; if (status !== 3'd0)     begin errors++; $display("FAIL midrun status: got %0d want 0", status); end
      checks++; if (cycle_count !== '0)  begin errors++; $display("FAIL midrun cycle_count: got %0d want 0", cycle_count); end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_done_run();
      int unsigned ecnt; logic [2:0] est;
      fill_regfile(); done_at = 100; bkpt_en = 1'b0;
      ref_run(done_at, 0, 1'b0, ecnt, est);
      do_run(32'h0, 0, -1, -1, -1);
      checks++; if (obs_timeout)            begin errors++; $display("FAIL done timeout: run did not finish"); end
      checks++; if (obs_rst_hi != RST_CYC)  begin errors++; $display("FAIL done cpu_reset cycles: got %0d want %0d", obs_rst_hi, RST_CYC); end
      checks++; if (obs_cc != ecnt)         begin errors++; $display("FAIL done cycle_count: got %0d want %0d", obs_cc, ecnt); end
      checks++; if (executed != ecnt)       begin errors++; $display("FAIL done cpu edges: got %0d want %0d", executed, ecnt); end
      checks++; if (obs_st !== est)         begin errors++; $display("FAIL done status: got %0d want %0d", obs_st, est); end
      checks++; if (obs_fin != 1)           begin errors++; $display("FAIL done finished pulses: got %0d want 1", obs_fin); end
      checks++; if (obs_tail_busy != 0)     begin errors++; $display("FAIL done idle after end: got %0d busy cycles want 0", obs_tail_busy); end
      checks++; if (obs_idx_q.size() != DUMP_N) begin errors++; $display("FAIL done beat count: got %0d want %0d", obs_idx_q.size(), DUMP_N); end
      for (int i = 0; i < obs_idx_q.size() && i < DUMP_N; i++) begin
         checks++;
         if (obs_idx_q[i] !== 5'(i) || obs_data_q[i] !== regfile[i]) begin
            errors++; $display("FAIL done beat %0d: got idx=%0d data=%h want idx=%0d data=%h", i, obs_idx_q[i], obs_data_q[i], i, regfile[i]);
         end
      end
   endtask

   task automatic test_timeout();
      int unsigned ecnt; logic [2:0] est;
      fill_regfile(); done_at = 0; bkpt_en = 1'b0;
      ref_run(done_at, 0, 1'b0, ecnt, est);
      do_run(32'h400, 0, -1, -1, -1);
      checks++; if (obs_timeout)       begin errors++; $display("FAIL timeout run did not finish"); end
      checks++; if (obs_cc != ecnt)    begin errors++; $display("FAIL timeout cycle_count: got %0d want %0d", obs_cc, ecnt); end
      checks++; if (executed != ecnt)  begin errors++; $display("FAIL timeout cpu edges: got %0d want %0d", executed, ecnt); end
      checks++; if (obs_st !== est)    begin errors++; $display("FAIL timeout status: got %0d want %0d", obs_st, est); end
      checks++; if (obs_idx_q.size() != DUMP_N) begin errors++; $display("FAIL timeout beat count: got %0d want %0d", obs_idx_q.size(), DUMP_N); end
      for (int i = 0; i < obs_idx_q.size() && i < DUMP_N; i++) begin
         checks++;
         if (obs_idx_q[i] !== 5'(i) || obs_data_q[i] !== regfile[i]) begin
            errors++; $display("FAIL timeout beat %0d: got idx=%0d data=%h want idx=%0d data=%h", i, obs_idx_q[i], obs_data_q[i], i, regfile[i]);
         end
      end
   endtask

   task automatic test_ready_alternate();
      int unsigned ecnt; logic [2:0] est;
      fill_regfile(); done_at = $urandom_range(20, 200); bkpt_en = 1'b0;
      ref_run(done_at, 0, 1'b0, ecnt, est);
      do_run(32'h0, 1, -1, -1, -1);
      checks++; if (obs_timeout)         begin errors++; $display("FAIL alt run did not finish"); end
      checks++; if (obs_hold_err != 0)   begin errors++; $display("FAIL alt beat stability: got %0d changes while stalled want 0", obs_hold_err); end
      checks++; if (obs_cc != ecnt || obs_st !== est) begin errors++; $display("FAIL alt outcome: got cnt=%0d st=%0d want cnt=%0d st=%0d", obs_cc, obs_st, ecnt, est); end
      checks++; if (obs_idx_q.size() != DUMP_N) begin errors++; $display("FAIL alt beat count: got %0d want %0d", obs_idx_q.size(), DUMP_N); end
      for (int i = 0; i < obs_idx_q.size() && i < DUMP_N; i++) begin
         checks++;
         if (obs_idx_q[i] !== 5'(i) || obs_data_q[i] !== regfile[i]) begin
            errors++; $display("FAIL alt beat %0d: got idx=%0d data=%h want idx=%0d data=%h", i, obs_idx_q[i], obs_data_q[i], i, regfile[i]);
         end
      end
   endtask

   task automatic test_bkpt();
      int unsigned ecnt; logic [2:0] est;
      fill_regfile(); done_at = 60; bkpt_en = 1'b1; bkpt_addr = 32'h20;
      ref_run(done_at, (32'h20 - 32'h0) / 4, 1'b1, ecnt, est);
      do_run(32'h0, 2, -1, -1, -1);
      bkpt_en = 1'b0;
      checks++; if (obs_timeout)       begin errors++; $display("FAIL bkpt run did not finish"); end
      checks++; if (obs_cc != ecnt)    begin errors++; $display("FAIL bkpt cycle_count: got %0d want %0d", obs_cc, ecnt); end
      checks++; if (executed != ecnt)  begin errors++; $display("FAIL bkpt cpu edges: got %0d want %0d", executed, ecnt); end
      checks++; if (obs_st !== est)    begin errors++; $display("FAIL bkpt status: got %0d want %0d", obs_st, est); end
      checks++; if (obs_idx_q.size() != DUMP_N) begin errors++; $display("FAIL bkpt beat count: got %0d want %0d", obs_idx_q.size(), DUMP_N); end
   endtask

   task automatic test_abort_run();
      done_at = 0; bkpt_en = 1'b0;
      do_run(32'h80, 0, -1, -1, 40);
      checks++; if (obs_timeout)                 begin errors++; $display("FAIL abortrun did not finish"); end
      checks++; if (obs_cc != 40 - RST_CYC)      begin errors++; $display("FAIL abortrun cycle_count: got %0d want %0d", obs_cc, 40 - RST_CYC); end
      checks++; if (executed != 40 - RST_CYC)    begin errors++; $display("FAIL abortrun cpu edges: got %0d want %0d", executed, 40 - RST_CYC); end
      checks++; if (obs_st !== 3'd4)             begin errors++; $display("FAIL abortrun status: got %0d want 4", obs_st); end
      checks++; if (obs_idx_q.size() != 0)       begin errors++; $display("FAIL abortrun beats: got %0d want 0", obs_idx_q.size()); end
      checks++; if (obs_fin != 1)                begin errors++; $display("FAIL abortrun finished pulses: got %0d want 1", obs_fin); end
   endtask

   task automatic test_abort_dump();
      fill_regfile(); done_at = $urandom_range(10, 150); bkpt_en = 1'b0;
      do_run(32'hC0, 2, 10, 5, -1);
      checks++; if (obs_timeout)                 begin errors++; $display("FAIL abortdump did not finish"); end
      checks++; if (obs_dv_after_abort !== 1'b0) begin errors++; $display("FAIL abortdump dump_valid next cycle: got %b want 0", obs_dv_after_abort); end
      checks++; if (obs_st_after_abort !== 3'd4) begin errors++; $display("FAIL abortdump status next cycle: got %0d want 4", obs_st_after_abort); end
      checks++; if (obs_fin != 1)                begin errors++; $display("FAIL abortdump finished pulses: got %0d want 1", obs_fin); end
      checks++; if (obs_tail_busy != 0)          begin errors++; $display("FAIL abortdump restart after end: got %0d busy cycles want 0", obs_tail_busy); end
      checks++; if (cpu_start_addr !== 32'hC0)   begin errors++; $display("FAIL abortdump start_addr: got %h want c0", cpu_start_addr); end
      checks++; if (obs_cc != done_at)           begin errors++; $display("FAIL abortdump cycle_count: got %0d want %0d", obs_cc, done_at); end
      checks++; if (obs_hold_err != 0)           begin errors++; $display("FAIL abortdump beat stability: got %0d want 0", obs_hold_err); end
      checks++; if (obs_idx_q.size() != 10)      begin errors++; $display("FAIL abortdump beats: got %0d want 10", obs_idx_q.size()); end
      for (int i = 0; i < obs_idx_q.size() && i < 10; i++) begin
         checks++;
         if (obs_idx_q[i] !== 5'(i) || obs_data_q[i] !== regfile[i]) begin
            errors++; $display("FAIL abortdump beat %0d: got idx=%0d data=%h want idx=%0d data=%h", i, obs_idx_q[i], obs_data_q[i], i, regfile[i]);
         end
      end
   endtask

   task automatic test_random_runs();
      int unsigned ecnt; logic [2:0] est;
      logic [31:0] addr;
      for (int n = 0; n < 3; n++) begin
         fill_regfile(); done_at = $urandom_range(1, 400); bkpt_en = 1'b0;
         addr = $urandom & 32'hFFFF_FFFC;
         ref_run(done_at, 0, 1'b0, ecnt, est);
         do_run(addr, 2, -1, -1, -1);
         checks++; if (obs_timeout)     begin errors++; $display("FAIL rand%0d did not finish", n); end
         checks++; if (obs_cc != ecnt || obs_st !== est) begin errors++; $display("FAIL rand%0d outcome: got cnt=%0d st=%0d want cnt=%0d st=%0d", n, obs_cc, obs_st, ecnt, est); end
         checks++; if (obs_hold_err != 0 || obs_idx_q.size() != DUMP_N) begin errors++; $display("FAIL rand%0d dump: got holderr=%0d beats=%0d want 0/%0d", n, obs_hold_err, obs_idx_q.size(), DUMP_N); end
         for (int i = 0; i < obs_idx_q.size() && i < DUMP_N; i++) begin
            checks++;
            if (obs_idx_q[i] !== 5'(i) || obs_data_q[i] !== regfile[i]) begin
               errors++; $display("FAIL rand%0d beat %0d: got idx=%0d data=%h want idx=%0d data=%h", n, i, obs_idx_q[i], obs_data_q[i], i, regfile[i]);
            end
         end
      end
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; start_addr = '0; abort = 1'b0;
      bkpt_en = 1'b0; bkpt_addr = '0; dump_ready = 1'b0;
      fill_regfile();
      test_reset();
      test_done_run();
      test_reset_mid_run();
      test_timeout();
      test_ready_alternate();
      test_bkpt();
      test_abort_run();
      test_abort_dump();
      test_random_runs();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
